// File: rtl/jzjpcc_mmio_uart_tx.sv
// rtl/jzjpcc_mmio_uart_tx.sv - MMIO toggle/ack byte port feeding a FIFO and an 8N1 serial transmitter
module jzjpcc_mmio_uart_tx #(
  parameter int CLOCKS_PER_BIT  = 434,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mmioOutputWord,
  output logic [31:0] mmioInputWord,
  output logic        txd
);

  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int BAUD_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [BAUD_W-1:0]        BAUD_MAX   = BAUD_W'(CLOCKS_PER_BIT - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]                 fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count, count_n;
  logic                       ack, ack_n;
  state_t                     state, state_n;
  logic [2:0]                 bit_cnt, bit_cnt_n;
  logic [BAUD_W-1:0]          baud, baud_n;
  logic [7:0]                 shift, shift_n;
  logic                       txd_n;
  logic [31:0]                status_n;
  logic                       full, empty, push, pop;
  logic                       unused_upper;

  assign unused_upper = &mmioOutputWord[31:9];

  // Level compare against the registered ack: a request stays pending while full.
  assign full  = (count == COUNT_FULL);
  assign empty = (count == '0);
  assign push  = (mmioOutputWord[8] != ack) && !full;

  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = fifo_mem[rd_ptr];
          baud_n  = BAUD_MAX;
          state_n = START;
        end
      end
      START: begin
        if (baud == '0) begin
          baud_n    = BAUD_MAX;
          bit_cnt_n = 3'd0;
          state_n   = DATA;
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      DATA: begin
        if (baud == '0) begin
          baud_n  = BAUD_MAX;
          shift_n = {1'b0, shift[7:1]};
          if (bit_cnt == 3'd7) state_n = STOP;
          else bit_cnt_n = bit_cnt + 3'd1;
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      STOP: begin
        if (baud == '0) begin
          // Chain straight into the next start bit so frames are gapless.
          if (!empty) begin
            pop     = 1'b1;
            shift_n = fifo_mem[rd_ptr];
            baud_n  = BAUD_MAX;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    count_n = count;
    if (push && !pop)      count_n = count + 1'b1;
    else if (!push && pop) count_n = count - 1'b1;
    ack_n = ack ^ push;
  end

  // txd and the status word are registered from post-edge state.
  always_comb begin
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shift_n[0];
      default: txd_n = 1'b1;
    endcase
    status_n        = '0;
    status_n[8]     = ack_n;
    status_n[9]     = (count_n == COUNT_FULL);
    status_n[10]    = (count_n == '0);
    status_n[11]    = (state_n == IDLE) && (count_n == '0);
    status_n[16:12] = 5'(count_n);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      ack           <= 1'b0;
      state         <= IDLE;
      bit_cnt       <= '0;
      baud          <= '0;
      shift         <= '0;
      txd           <= 1'b1;
      mmioInputWord <= 32'h0000_0C00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count         <= count_n;
      ack           <= ack_n;
      state         <= state_n;
      bit_cnt       <= bit_cnt_n;
      baud          <= baud_n;
      shift         <= shift_n;
      txd           <= txd_n;
      mmioInputWord <= status_n;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) fifo_mem[wr_ptr] <= mmioOutputWord[7:0];
  end

endmodule

// File: doc/jzjpcc_mmio_uart_tx.md
# jzjpcc_mmio_uart_tx

Memory-mapped UART transmitter that sits on the far side of one jzjpcc MMIO port pair. It consumes one `mmioOutputs[n]` word written by the core and drives one `mmioInputs[n]` status word back. Bytes are handed over with a toggle/acknowledge handshake, buffered in a small FIFO, and serialised as 8N1 frames on `txd`. Software writes a byte with a flipped request bit, then polls until the acknowledge bit matches.

## Interface
- `CLOCKS_PER_BIT`, 434: clock cycles per serial bit. Legal values are ≥ 2. The baud counter width is `$clog2(CLOCKS_PER_BIT)`.
- `FIFO_DEPTH_LOG2`, 3: FIFO holds `2**FIFO_DEPTH_LOG2` bytes. Legal range 1..4.

- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `mmioOutputWord`  in  32  connects to the core's `mmioOutputs[n]`.
  - `[7:0]` data byte.
  - `[8]` request toggle.
  - `[31:9]` ignored.
- `mmioInputWord`  out  32  connects to the core's `mmioInputs[n]`; every field is registered.
  - `[8]` ack toggle.
  - `[9]` FIFO full.
  - `[10]` FIFO empty.
  - `[11]` done, defined as FSM in IDLE and FIFO empty.
  - `[16:12]` FIFO count, zero-extended.
  - `[7:0]` and `[31:17]` read as 0.
- `txd`  out  1  serial line; idles high; registered.

## Operation
- **Acceptance condition:** `mmioOutputWord[8] != ack && !full`, evaluated on the registered state.
  - When it holds, the block pushes `mmioOutputWord[7:0]` into the FIFO and inverts `ack`, both on the same edge.
  - This is a level compare, not edge detection. A request made while the FIFO is full stays pending and is accepted on the first edge where `full` is 0.
- **No push:** if `mmioOutputWord[8] == ack`, changes on `[7:0]` have no effect.
- **FIFO:** circular buffer with read/write pointers and a count of width `FIFO_DEPTH_LOG2+1`.
  - `full` = (count == depth); `empty` = (count == 0).
  - Pointers wrap modulo depth.
  - Push and pop on the same edge leave count unchanged.
  - Pop is only allowed when count ≠ 0 before the edge. A byte pushed at edge k is therefore first poppable at edge k+1.
- **Transmit FSM:** states IDLE, START, DATA, STOP. There is a bit counter (0..7), a baud counter, and an 8-bit shift register.
  - IDLE: `txd`=1. If FIFO is not empty, pop into the shift register, load the baud counter with `CLOCKS_PER_BIT-1`, and go to START.
  - START: `txd`=0. When the baud counter reaches 0, reload it, clear the bit counter, and go to DATA.
  - DATA: `txd`=shift[0] (LSB first). When the baud counter reaches 0, reload it and shift right.
    - If the bit counter is 7, go to STOP.
    - Otherwise increment the bit counter.
  - STOP: `txd`=1. When the baud counter reaches 0:
    - If FIFO is not empty, pop, reload, and go directly to START. Frames are gapless.
    - Otherwise go to IDLE.
- **Frame length:** exactly `10*CLOCKS_PER_BIT` cycles of `txd`.
- **Reset** (any state, including mid-frame) has these effects on the next edge:
  - FIFO is cleared, pointers and count go to 0.
  - `ack`=0.
  - FSM goes to IDLE and `txd`=1.
  - `mmioInputWord`=0x00000C00.
  - Any partial frame is truncated and not resumed.
- **Integration requirement:** if `mmioOutputWord[8]`=1 when reset is released, one byte is accepted on the first edge. Software must start with the request bit equal to `ack`=0.

## Timing
- Request visible on `mmioOutputWord` before edge E with the acceptance condition true:
  - push and ack toggle happen at E;
  - the new `ack` is visible after E.
- FSM idle with FIFO empty at E:
  - pop at E+1;
  - `txd` falls after E+1, i.e. 2 edges after the sampling edge.
- Status bits reflect state after each edge, so there is one cycle of lag relative to the internal push/pop decision.
- Throughput is one byte per `10*CLOCKS_PER_BIT` cycles. The buffering capacity is depth plus 1, the extra byte being the one in the shift register.
- Pop and push on the same edge are both performed. `full` is evaluated before the edge, so no push is performed into a slot freed on that same edge.

## Test plan
All scenarios use `CLOCKS_PER_BIT`=4 and `FIFO_DEPTH_LOG2`=2.

- **Reset:** hold `reset` 2 cycles with `mmioOutputWord`=0 → `txd`=1 and `mmioInputWord`=0x00000C00.
- **Single byte:** write 0x00000155 → `ack`=1 one cycle later.
  - `txd` is low for 4 cycles, then 1,0,1,0,1,0,1,0 for 4 cycles each, then high for 4 cycles.
  - After the stop bit, `mmioInputWord`=0x00000D00.
- **Back-to-back:** push 0xA0 (toggle 1), then 0x0F (toggle 0) → 80 contiguous frame cycles. The start bit of frame 2 follows the stop bit of frame 1 with no idle cycle. Data is LSB first.
- **FIFO full:** issue 6 requests rapidly, waiting for each ack.
  - Byte 1 goes into the shift register and bytes 2–5 fill the FIFO.
  - Status is then `full`=1 and count=4, i.e. word 0x00004000 | 0x200 | `ack`<<8.
  - Request 6 is not acked until frame 1's STOP pop, and is acked on the cycle after that pop.
- **Reset mid-frame:** assert `reset` during DATA bit 3 → `txd`=1 the next cycle and status 0x00000C00. No further frame is sent while the request bit is 0.
- **Held toggle:** keep `[8]`==`ack` while sweeping `[7:0]` over 0x00..0xFF → no push, and `txd` stays 1.
